// File: rtl/ctrl_pkg.sv
// Shared definitions for the weight-stationary instruction sequencer: instruction
// word field positions, the idle instruction word and the sequencer state encoding.
package ctrl_pkg;

   localparam int unsigned INST_W = 35;
   localparam int unsigned AddrW  = 11;

   localparam int unsigned BIT_MODE     = 34;
   localparam int unsigned BIT_ACC      = 33;
   localparam int unsigned BIT_CEN_P    = 32;
   localparam int unsigned BIT_WEN_P    = 31;
   localparam int unsigned A_P_MSB      = 30;
   localparam int unsigned A_P_LSB      = 20;
   localparam int unsigned BIT_CEN_X    = 19;
   localparam int unsigned BIT_WEN_X    = 18;
   localparam int unsigned A_X_MSB      = 17;
   localparam int unsigned A_X_LSB      = 7;
   localparam int unsigned BIT_OFIFO_RD = 6;
   localparam int unsigned BIT_IFIFO_WR = 5;
   localparam int unsigned BIT_IFIFO_RD = 4;
   localparam int unsigned BIT_L0_RD    = 3;
   localparam int unsigned BIT_L0_WR    = 2;
   localparam int unsigned BIT_EXEC     = 1;
   localparam int unsigned BIT_LOAD     = 0;

   // Both SRAMs disabled and write-protected (active-low strobes high), everything else 0.
   localparam logic [INST_W-1:0] IDLE_WORD = 35'h1_800C_0000;

   typedef enum logic [2:0] {
      StIdle,
      StWFetch,
      StWLoad,
      StWSettle,
      StXFetch,
      StXExec,
      StPWr,
      StDone
   } state_e;

endpackage

// File: rtl/seq_addr_gen.sv
// xmem read address generator: base + offset*stride + cnt (modulo 2^Aw), plus the
// read strobe delayed by the one-cycle SRAM read latency.
module seq_addr_gen
   import ctrl_pkg::*;
#(
   parameter int unsigned Aw = AddrW
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic [Aw-1:0] base_i,
   input  logic [Aw-1:0] offset_i,
   input  logic [Aw-1:0] stride_i,
   input  logic [Aw-1:0] cnt_i,
   input  logic          rd_en_i,
   output logic [Aw-1:0] addr_o,
   output logic          rd_dly_o
);

   logic rd_dly_q;

   assign addr_o   = base_i + offset_i * stride_i + cnt_i;
   assign rd_dly_o = rd_dly_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rd_dly_q <= 1'b0;
      end else begin
         rd_dly_q <= rd_en_i;
      end
   end

endmodule

// File: rtl/ws_inst_sequencer.sv
// Per-cycle instruction generator for one weight-stationary conv layer: for each kernel
// position fetch/load weights, fetch/execute activations, then drain the OFIFO to pmem.
module ws_inst_sequencer
   import ctrl_pkg::*;
#(
   parameter int unsigned Row    = 8,
   parameter int unsigned Col    = 8,
   parameter int unsigned LenKij = 9,
   parameter int unsigned LenNij = 36
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [AddrW-1:0]  w_base_i,
   input  logic [AddrW-1:0]  x_base_i,
   input  logic [AddrW-1:0]  p_base_i,
   input  logic              ofifo_valid_i,
   output logic [INST_W-1:0] inst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [3:0]        kij_idx_o
);

   localparam logic [AddrW-1:0] ColA    = AddrW'(Col);
   localparam logic [AddrW-1:0] NijA    = AddrW'(LenNij);
   localparam logic [AddrW-1:0] ColLast = AddrW'(Col - 1);
   localparam logic [AddrW-1:0] RowLast = AddrW'(Row - 1);
   localparam logic [AddrW-1:0] NijLast = AddrW'(LenNij - 1);
   localparam logic [3:0]       KijLast = 4'(LenKij - 1);

   state_e            state_q;
   logic [AddrW-1:0]  cnt_q;
   logic [3:0]        kij_q;
   logic [AddrW-1:0]  w_base_q, x_base_q, p_base_q;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              busy_q, done_q;

   logic              w_phase, rd_en, rd_dly;
   logic [AddrW-1:0]  x_addr, p_addr;

   assign w_phase = (state_q == StWFetch);
   assign rd_en   = (w_phase && (cnt_q < ColA)) || ((state_q == StXFetch) && (cnt_q < NijA));
   assign p_addr  = p_base_q + AddrW'(kij_q) * NijA + cnt_q;

   seq_addr_gen #(
      .Aw(AddrW)
   ) u_xaddr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .base_i  (w_phase ? w_base_q : x_base_q),
      .offset_i(w_phase ? AddrW'(kij_q) : '0),
      .stride_i(ColA),
      .cnt_i   (cnt_q),
      .rd_en_i (rd_en),
      .addr_o  (x_addr),
      .rd_dly_o(rd_dly)
   );

   // Word decode from the current state; registered into inst_q below.
   always_comb begin
      inst_d            = IDLE_WORD;
      inst_d[BIT_L0_WR] = rd_dly;
      unique case (state_q)
         StWFetch, StXFetch: begin
            if (rd_en) begin
               inst_d[BIT_CEN_X]       = 1'b0;
               inst_d[A_X_MSB:A_X_LSB] = x_addr;
            end
         end
         StWLoad: begin
            inst_d[BIT_L0_RD] = 1'b1;
            inst_d[BIT_LOAD]  = 1'b1;
         end
         StXExec: begin
            inst_d[BIT_L0_RD] = 1'b1;
            inst_d[BIT_EXEC]  = 1'b1;
         end
         StPWr: begin
            if (ofifo_valid_i) begin
               inst_d[BIT_OFIFO_RD]    = 1'b1;
               inst_d[BIT_CEN_P]       = 1'b0;
               inst_d[BIT_WEN_P]       = 1'b0;
               inst_d[A_P_MSB:A_P_LSB] = p_addr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         kij_q    <= '0;
         w_base_q <= '0;
         x_base_q <= '0;
         p_base_q <= '0;
         inst_q   <= IDLE_WORD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         inst_q <= inst_d;
         busy_q <= (state_q != StIdle) && (state_q != StDone);
         done_q <= (state_q == StDone);
         cnt_q  <= cnt_q + AddrW'(1);
         unique case (state_q)
            StIdle: begin
               cnt_q <= '0;
               kij_q <= '0;
               if (start_i) begin
                  state_q  <= StWFetch;
                  w_base_q <= w_base_i;
                  x_base_q <= x_base_i;
                  p_base_q <= p_base_i;
               end
            end
            StWFetch: begin
               if (cnt_q == ColA) begin
                  cnt_q   <= '0;
                  state_q <= StWLoad;
               end
            end
            StWLoad: begin
               if (cnt_q == ColLast) begin
                  cnt_q   <= '0;
                  state_q <= StWSettle;
               end
            end
            StWSettle: begin
               if (cnt_q == RowLast) begin
                  cnt_q   <= '0;
                  state_q <= StXFetch;
               end
            end
            StXFetch: begin
               if (cnt_q == NijA) begin
                  cnt_q   <= '0;
                  state_q <= StXExec;
               end
            end
            StXExec: begin
               if (cnt_q == NijLast) begin
                  cnt_q   <= '0;
                  state_q <= StPWr;
               end
            end
            StPWr: begin
               // cnt counts pops, so it holds while the OFIFO is empty.
               if (!ofifo_valid_i) begin
                  cnt_q <= cnt_q;
               end else if (cnt_q == NijLast) begin
                  cnt_q <= '0;
                  if (kij_q == KijLast) begin
                     state_q <= StDone;
                  end else begin
                     kij_q   <= kij_q + 4'd1;
                     state_q <= StWFetch;
                  end
               end
            end
            StDone: begin
               cnt_q   <= '0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign inst_o    = inst_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign kij_idx_o = kij_q;

endmodule

// File: tb/tb_ws_inst_sequencer.sv
// Scoreboard bench for ws_inst_sequencer: stimulus queues expected xmem/pmem addresses
// and done times; a negedge monitor pops and compares whenever the DUT issues them.
module tb_ws_inst_sequencer;
   import ctrl_pkg::*;

   localparam int ROW     = 8;
   localparam int COL     = 8;
   localparam int KIJ     = 9;
   localparam int NIJ     = 36;
   localparam int PER_KIJ = (COL + 1) + COL + ROW + (NIJ + 1) + NIJ + NIJ;
   localparam int AMASK   = 2047;

   logic              clk = 1'b0;
   logic              reset, start, ofifo_valid;
   logic [AddrW-1:0]  w_base, x_base, p_base;
   logic [INST_W-1:0] inst;
   logic              busy, done;
   logic [3:0]        kij_idx;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int exp_x[$];
   int exp_p[$];
   int exp_done[$];
   int n_load, n_exec, n_l0wr, n_pw, n_done;
   logic prev_rd = 1'b0;
   logic valid_at_edge = 1'b0;

   ws_inst_sequencer #(
      .Row(ROW), .Col(COL), .LenKij(KIJ), .LenNij(NIJ)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .start_i      (start),
      .w_base_i     (w_base),
      .x_base_i     (x_base),
      .p_base_i     (p_base),
      .ofifo_valid_i(ofifo_valid),
      .inst_o       (inst),
      .busy_o       (busy),
      .done_o       (done),
      .kij_idx_o    (kij_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc           <= cyc + 1;
      valid_at_edge <= ofifo_valid;
   end

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_now(input string name, input longint act);
      checks++;
      errors++;
      $display("FAIL %s: got 0x%0h, required none (cycle %0d)", name, act, cyc);
   endtask

   // Monitor: compares every transaction the DUT presents against the queues.
   always @(negedge clk) begin
      if (!reset) begin
         chk("tied_bits", {inst[BIT_MODE], inst[BIT_ACC], inst[BIT_IFIFO_WR],
                           inst[BIT_IFIFO_RD], inst[BIT_WEN_X]}, 5'b00001);
         chk("l0_wr_delay", inst[BIT_L0_WR], prev_rd);
         chk("l0_rd_decode", inst[BIT_L0_RD], inst[BIT_LOAD] | inst[BIT_EXEC]);
         if (!inst[BIT_CEN_X]) begin
            if (exp_x.size() == 0) fail_now("xmem_unexpected", inst[A_X_MSB:A_X_LSB]);
            else chk("xmem_addr", inst[A_X_MSB:A_X_LSB], exp_x.pop_front());
         end
         if (inst[BIT_OFIFO_RD]) begin
            n_pw++;
            chk("pmem_strobes", {inst[BIT_CEN_P], inst[BIT_WEN_P]}, 2'b00);
            chk("pop_needs_valid", valid_at_edge, 1'b1);
            if (exp_p.size() == 0) fail_now("pmem_unexpected", inst[A_P_MSB:A_P_LSB]);
            else chk("pmem_addr", inst[A_P_MSB:A_P_LSB], exp_p.pop_front());
         end else begin
            chk("pmem_idle", {inst[BIT_CEN_P], inst[BIT_WEN_P], inst[A_P_MSB:A_P_LSB]},
                {2'b11, 11'h0});
         end
         if (inst[BIT_LOAD]) n_load++;
         if (inst[BIT_EXEC]) n_exec++;
         if (inst[BIT_L0_WR]) n_l0wr++;
         if (done) begin
            n_done++;
            chk("busy_at_done", busy, 1'b0);
            if (exp_done.size() == 0) fail_now("done_unexpected", cyc);
            else begin
               int e;
               e = exp_done.pop_front();
               if (e >= 0) chk("done_cycle", cyc, e);
            end
         end
         prev_rd = ~inst[BIT_CEN_X];
      end
   end

   task automatic clear_counts();
      n_load = 0; n_exec = 0; n_l0wr = 0; n_pw = 0;
   endtask

   task automatic push_layer(input int wb, input int xb, input int pb, input int nkij);
      for (int k = 0; k < nkij; k++) begin
         for (int c = 0; c < COL; c++) exp_x.push_back((wb + k * COL + c) & AMASK);
         for (int n = 0; n < NIJ; n++) exp_x.push_back((xb + n) & AMASK);
         for (int n = 0; n < NIJ; n++) exp_p.push_back((pb + k * NIJ + n) & AMASK);
      end
   endtask

   task automatic pulse_start(input int wb, input int xb, input int pb, output int s);
      @(posedge clk); #1;
      start = 1'b1; w_base = AddrW'(wb); x_base = AddrW'(xb); p_base = AddrW'(pb);
      s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      int d0;
      d0 = n_done;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk); #1;
         if (n_done != d0) break;
      end
      chk("done_seen", n_done - d0, 1);
   endtask

   task automatic check_layer_totals(input int nkij);
      chk("xmem_left", exp_x.size(), 0);
      chk("pmem_left", exp_p.size(), 0);
      chk("load_count", n_load, nkij * COL);
      chk("exec_count", n_exec, nkij * NIJ);
      chk("l0_wr_count", n_l0wr, nkij * (COL + NIJ));
      chk("pmem_count", n_pw, nkij * NIJ);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   initial begin
      int s;
      bit tog_stop;
      reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
      w_base = '0; x_base = '0; p_base = '0;
      n_done = 0;
      clear_counts();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_inst", inst, IDLE_WORD);
         chk("idle_busy", busy, 1'b0);
         chk("idle_done", done, 1'b0);
         chk("idle_kij", kij_idx, 4'd0);
      end

      // Full layer, OFIFO always valid, start re-pulsed while busy
      ofifo_valid = 1'b1;
      clear_counts();
      push_layer('h10, 'h100, 'h400, KIJ);
      pulse_start('h10, 'h100, 'h400, s);
      exp_done.push_back(s + 2 + KIJ * PER_KIJ);
      repeat (50) @(posedge clk);
      #1 chk("busy_mid", busy, 1'b1);
      pulse_start('h555, 'h666, 'h777, s);
      wait_done(3 * KIJ * PER_KIJ);
      @(negedge clk);
      chk("busy_after", busy, 1'b0);
      check_layer_totals(KIJ);

      // Abort with reset during X_EXEC of kij 0
      clear_counts();
      for (int c = 0; c < COL; c++) exp_x.push_back('h20 + c);
      for (int n = 0; n < NIJ; n++) exp_x.push_back('h200 + n);
      pulse_start('h20, 'h200, 'h300, s);
      for (int i = 0; i < 2 * PER_KIJ; i++) begin
         @(negedge clk);
         if (inst[BIT_EXEC]) break;
      end
      chk("exec_reached", inst[BIT_EXEC], 1'b1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_inst", inst, IDLE_WORD);
      chk("abort_busy", busy, 1'b0);
      chk("abort_kij", kij_idx, 4'd0);
      chk("abort_xmem_left", exp_x.size(), 0);
      chk("abort_pmem", n_pw, 0);

      // Fresh start replays from kij 0; OFIFO toggles every 3 cycles; pmem wraps
      clear_counts();
      ofifo_valid = 1'b0;
      tog_stop = 1'b0;
      push_layer('h30, 'h140, 'h7F0, KIJ);
      exp_done.push_back(-1);
      fork
         begin
            pulse_start('h30, 'h140, 'h7F0, s);
            wait_done(4 * KIJ * PER_KIJ);
            tog_stop = 1'b1;
         end
         begin
            while (!tog_stop) begin
               repeat (3) @(posedge clk);
               #1 ofifo_valid = ~ofifo_valid;
            end
         end
      join
      @(negedge clk);
      check_layer_totals(KIJ);
      chk("done_pulses", n_done, 2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
